// File: rtl/decoder_grant_arbiter_pkg.sv
// Shared types and constants for the round-robin grant arbiter.
// State encoding, requester count and index width.
package decoder_grant_arbiter_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef logic [1:0]         state_t;
    typedef logic [NUM_REQ-1:0] req_vec_t;
    typedef logic [IDX_W-1:0]   idx_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t GRANT = 2'd1;
    localparam state_t GAP   = 2'd2;

endpackage

// File: rtl/grant_decoder_3to8.sv
// Combinational 3-to-8 one-hot decoder with enable.
// Ports: idx_i (binary index), en_i (enable), onehot_o (one-hot, zero when disabled).
module grant_decoder_3to8
    import decoder_grant_arbiter_pkg::*;
(
    input  logic [IDX_W-1:0]   idx_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_grant_arbiter.sv
// Round-robin arbiter over eight requesters with hold-time limit.
// Ports: clk, rst (async, active-high), req_i, release_i,
//        grant_o, grant_idx_o, grant_valid_o, timeout_o, busy_o.
module decoder_grant_arbiter
    import decoder_grant_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               release_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               grant_valid_o,
    output logic               timeout_o,
    output logic               busy_o
);

    // Returns {found, index} of the first set bit after ptr, wrapping.
    // Scanning from the farthest candidate down lets the nearest win.
    function automatic logic [IDX_W:0] rr_pick(
        input req_vec_t req,
        input idx_t     ptr
    );
        logic [IDX_W:0] res;
        idx_t           c;
        res = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            c = ptr + idx_t'(i);
            if (req[c]) begin
                res = {1'b1, c};
            end
        end
        return res;
    endfunction

    state_t            state_q, state_d;
    idx_t              ptr_q, ptr_d;
    idx_t              idx_q, idx_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    req_vec_t          grant_q, grant_d;
    logic              valid_q, valid_d;
    logic              timeout_q, timeout_d;
    logic              busy_q, busy_d;

    logic [IDX_W:0]    pick;
    logic              pick_found;
    idx_t              pick_idx;
    logic              owner_exit;
    logic              hold_done;
    req_vec_t          dec_onehot;

    assign pick       = rr_pick(req_i, ptr_q);
    assign pick_found = pick[IDX_W];
    assign pick_idx   = pick[IDX_W-1:0];

    // Owner-driven exit beats the hold limit.
    assign owner_exit = release_i || !req_i[idx_q];
    assign hold_done  = (hold_cnt_q == CNT_W'(HOLD_MAX - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (owner_exit || hold_done) begin
                    state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    idx_d      = pick_idx;
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                timeout_d  = hold_done && !owner_exit;
            end
            GAP: begin
                ptr_d = idx_q;
            end
            default: ;
        endcase
        valid_d = (state_d == GRANT);
        busy_d  = (state_d != IDLE);
    end

    // Decode the upcoming owner so the registered grant tracks the state.
    grant_decoder_3to8 u_dec (
        .idx_i    (idx_d),
        .en_i     (valid_d),
        .onehot_o (dec_onehot)
    );

    assign grant_d = dec_onehot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= idx_t'(NUM_REQ - 1);
            idx_q      <= '0;
            hold_cnt_q <= '0;
            grant_q    <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_idx_o   = idx_q;
    assign grant_valid_o = valid_q;
    assign timeout_o     = timeout_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_decoder_grant_arbiter.sv
// Self-checking bench: three arbiters (HOLD_MAX 15, 4, 2) share stimulus,
// each compared every cycle against an owner/gap reference model.
module tb_decoder_grant_arbiter;

    localparam int ND = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       rel;

    logic [7:0] g  [ND];
    logic [2:0] gi [ND];
    logic       gv [ND];
    logic       to [ND];
    logic       bz [ND];

    always #5 clk = ~clk;

    decoder_grant_arbiter #(.HOLD_MAX(15), .CNT_W(8)) u_d15 (
        .clk(clk), .rst(rst), .req_i(req), .release_i(rel),
        .grant_o(g[0]), .grant_idx_o(gi[0]), .grant_valid_o(gv[0]),
        .timeout_o(to[0]), .busy_o(bz[0])
    );

    decoder_grant_arbiter #(.HOLD_MAX(4), .CNT_W(3)) u_d4 (
        .clk(clk), .rst(rst), .req_i(req), .release_i(rel),
        .grant_o(g[1]), .grant_idx_o(gi[1]), .grant_valid_o(gv[1]),
        .timeout_o(to[1]), .busy_o(bz[1])
    );

    decoder_grant_arbiter #(.HOLD_MAX(2), .CNT_W(2)) u_d2 (
        .clk(clk), .rst(rst), .req_i(req), .release_i(rel),
        .grant_o(g[2]), .grant_idx_o(gi[2]), .grant_valid_o(gv[2]),
        .timeout_o(to[2]), .busy_o(bz[2])
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: who owns the bus, how long, and the gap cycle.
    int hm   [ND] = '{15, 4, 2};
    int own  [ND];
    int held [ND];
    int gap  [ND];
    int last [ND];
    int midx [ND];
    bit mto  [ND];
    string phase;

    task automatic m_reset();
        for (int k = 0; k < ND; k++) begin
            own[k]  = -1;
            held[k] = 0;
            gap[k]  = 0;
            last[k] = 7;
            midx[k] = 0;
            mto[k]  = 1'b0;
        end
    endtask

    task automatic m_step();
        int c;
        for (int k = 0; k < ND; k++) begin
            mto[k] = 1'b0;
            if (own[k] >= 0) begin
                held[k]++;
                if (rel || !req[own[k]]) begin
                    last[k] = own[k];
                    own[k]  = -1;
                    gap[k]  = 1;
                end else if (held[k] == hm[k]) begin
                    last[k] = own[k];
                    own[k]  = -1;
                    gap[k]  = 1;
                    mto[k]  = 1'b1;
                end
            end else if (gap[k] != 0) begin
                gap[k] = 0;
            end else begin
                for (int i = 1; i <= 8; i++) begin
                    c = (last[k] + i) % 8;
                    if (own[k] < 0 && req[c]) begin
                        own[k]  = c;
                        held[k] = 0;
                        midx[k] = c;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        logic [7:0] eg;
        for (int k = 0; k < ND; k++) begin
            eg = (own[k] >= 0) ? 8'(1 << own[k]) : 8'h00;
            chk($sformatf("%s.d%0d", phase, k),
                {18'd0, g[k], gi[k], gv[k], to[k], bz[k]},
                {18'd0, eg, 3'(midx[k]), own[k] >= 0, mto[k],
                 (own[k] >= 0) || (gap[k] != 0)});
        end
    endtask

    task automatic step(input logic [7:0] r, input logic rl);
        req = r;
        rel = rl;
        @(posedge clk);
        m_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(8'h00, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_reset();
        check_all();
        @(negedge clk);
        check_all();
        rst = 1'b0;
    endtask

    int   q[$];
    int   tcnt;
    int   gcnt;
    logic [7:0] rr;
    logic       rl;

    initial begin
        req = 8'h00;
        rel = 1'b0;
        phase = "reset";
        do_reset();

        phase = "single";
        step(8'h04, 1'b0);
        chk("single_grant", {24'd0, g[0]}, 32'h04);
        chk("single_idx", {29'd0, gi[0]}, 32'd2);
        step(8'h04, 1'b0);
        step(8'h04, 1'b0);
        step(8'h00, 1'b0);
        chk("single_drop", {24'd0, g[0]}, 32'h00);
        idle(2);

        phase = "rr";
        do_reset();
        for (int i = 0; i < 27; i++) begin
            step(8'hFF, 1'b1);
            if (gv[0]) q.push_back(int'(gi[0]));
        end
        chk("rr_count", q.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < q.size()) chk("rr_order", q[i], i % 8);
        end

        phase = "tmo";
        idle(4);
        tcnt = 0;
        gcnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(8'h80, 1'b0);
            if (to[1]) tcnt++;
            if (g[1] == 8'h80) gcnt++;
        end
        chk("tmo_pulses", tcnt, 2);
        chk("tmo_grant_cycles", gcnt, 8);

        phase = "wrap";
        idle(4);
        step(8'h40, 1'b0);
        chk("wrap_first6", {29'd0, gi[0]}, 32'd6);
        step(8'h40, 1'b1);
        step(8'h41, 1'b0);
        step(8'h41, 1'b0);
        chk("wrap_to0", {24'd0, g[0]}, 32'h01);
        step(8'h41, 1'b1);
        step(8'h41, 1'b0);
        step(8'h41, 1'b0);
        chk("wrap_back6", {24'd0, g[0]}, 32'h40);
        step(8'h41, 1'b1);

        phase = "simul";
        idle(4);
        step(8'h01, 1'b0);
        step(8'h01, 1'b0);
        step(8'h00, 1'b1);
        chk("simul_no_tmo", {31'd0, to[2]}, 32'd0);
        chk("simul_exit", {24'd0, g[2]}, 32'h00);

        phase = "rst_mid";
        idle(4);
        step(8'h08, 1'b0);
        chk("pre_rst_idx", {29'd0, gi[0]}, 32'd3);
        do_reset();
        step(8'h09, 1'b0);
        chk("post_rst_grant", {24'd0, g[0]}, 32'h01);

        phase = "rand";
        rr = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) rr = 8'($urandom);
            rl = ($urandom_range(0, 4) == 0);
            step(rr, rl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
